// File: rtl/pixel_axis_bridge_if.sv
// AXI4-Stream bundle carrying pixels plus frame markers (tuser = start of
// frame, tlast = end of line) from the bridge to its downstream sink.
interface pixel_axis_bridge_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tuser;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/pixel_axis_bridge.sv
// Bridges the emboss filter's free-running pixel stream onto AXI4-Stream.
// Pixels are tagged with SOF/EOL/EOF from input-side counters, buffered in a
// small first-word-fall-through FIFO, and dropped (with a sticky overflow
// flag) when the sink stalls longer than the FIFO can absorb. Counters keep
// advancing on dropped pixels so frame markers never slip.
module pixel_axis_bridge #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 464,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pixel_valid,
  input  logic [DATA_WIDTH-1:0]         pixel_in,
  input  logic                          clear_overflow,
  pixel_axis_bridge_if.master           m_axis,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 3;
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMAGE_HEIGHT - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  // Entry layout, MSB first: {eof, eol, sof, data}
  localparam int SOF_BIT = DATA_WIDTH;
  localparam int EOL_BIT = DATA_WIDTH + 1;
  localparam int EOF_BIT = DATA_WIDTH + 2;

  logic [CW-1:0] colCnt_q, colCnt_d;
  logic [RW-1:0] rowCnt_q, rowCnt_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic          tvalid_q, tvalid_d;
  logic          overflow_q, overflow_d;
  logic          frameDone_q, frameDone_d;

  logic [EW-1:0] mem_q [FIFO_DEPTH];

  logic          inSof;
  logic          inEol;
  logic          inEof;
  logic          push;
  logic          pop;
  logic [EW-1:0] headEntry;

  // Next-state logic: marker tagging, push/pop arbitration, occupancy and flags
  always_comb begin
    inSof     = (colCnt_q == '0) && (rowCnt_q == '0);
    inEol     = (colCnt_q == COL_LAST);
    inEof     = inEol && (rowCnt_q == ROW_LAST);
    headEntry = mem_q[rdPtr_q];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    pop  = tvalid_q && m_axis.tready;
    push = pixel_valid && ((level_q != LEVEL_FULL) || pop);

    colCnt_d = colCnt_q;
    rowCnt_d = rowCnt_q;
    if (pixel_valid) begin
      if (inEol) begin
        colCnt_d = '0;
        rowCnt_d = (rowCnt_q == ROW_LAST) ? '0 : rowCnt_q + RW'(1);
      end else begin
        colCnt_d = colCnt_q + CW'(1);
      end
    end

    wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    tvalid_d = (level_d != '0);

    // A drop in the same cycle as a clear request keeps the flag set
    overflow_d = overflow_q;
    if (pixel_valid && !push) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end

    frameDone_d = pop && headEntry[EOF_BIT];
  end

  // Control state: counters, pointers, occupancy and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colCnt_q    <= '0;
      rowCnt_q    <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      tvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      colCnt_q    <= colCnt_d;
      rowCnt_q    <= rowCnt_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      tvalid_q    <= tvalid_d;
      overflow_q  <= overflow_d;
      frameDone_q <= frameDone_d;
    end
  end

  // Pixel storage; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {inEof, inEol, inSof, pixel_in};
    end
  end

  // Head entry is shown only while valid so an empty FIFO drives zeros
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tvalid_q ? headEntry[DATA_WIDTH-1:0] : '0;
  assign m_axis.tuser  = tvalid_q & headEntry[SOF_BIT];
  assign m_axis.tlast  = tvalid_q & headEntry[EOL_BIT];

  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_pixel_axis_bridge.sv
// Directed bench for pixel_axis_bridge on a 4x2 frame with a 16-entry FIFO.
module tb_pixel_axis_bridge;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 16;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          pixelValid;
  logic [DW-1:0] pixelIn;
  logic          clearOverflow;
  logic [4:0]    fifoLevel;
  logic          overflowFlag;
  logic          frameDone;

  int checkCount;
  int failCount;

  logic [9:0] gotBeats[$];
  logic [9:0] expBeats[$];
  int         doneCount;
  int         doneAtBeat;

  pixel_axis_bridge_if #(.DATA_WIDTH(DW)) axisIf ();

  pixel_axis_bridge #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pixel_valid   (pixelValid),
    .pixel_in      (pixelIn),
    .clear_overflow(clearOverflow),
    .m_axis        (axisIf),
    .fifo_level    (fifoLevel),
    .overflow      (overflowFlag),
    .frame_done    (frameDone)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Abort if the run ever stops making progress
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Record each transferred beat as {tuser, tlast, tdata} and frame_done pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (frameDone) begin
        doneCount  = doneCount + 1;
        doneAtBeat = gotBeats.size();
      end
      if (axisIf.tvalid && axisIf.tready) begin
        gotBeats.push_back({axisIf.tuser, axisIf.tlast, axisIf.tdata});
      end
    end
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of input, then return just after the capturing edge
  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                               input logic clear);
    pixelValid    = valid;
    pixelIn       = data;
    clearOverflow = clear;
    @(posedge clk);
    #1;
    pixelValid    = 1'b0;
    clearOverflow = 1'b0;
  endtask

  task automatic expectBeat(input logic [DW-1:0] data, input logic user,
                            input logic last);
    expBeats.push_back({user, last, data});
  endtask

  // Compare beats captured since 'base' against the expected list, then reset it
  task automatic compareBeats(input string tag, input int base);
    checkOutput($sformatf("%s_count", tag), 32'(gotBeats.size() - base),
                32'(expBeats.size()));
    for (int i = 0; i < expBeats.size(); i++) begin
      if (base + i < gotBeats.size()) begin
        checkOutput($sformatf("%s_beat%0d", tag, i),
                    32'(gotBeats[base + i]), 32'(expBeats[i]));
      end
    end
    expBeats.delete();
  endtask

  initial begin
    int beatBase;
    int doneBase;

    checkCount    = 0;
    failCount     = 0;
    doneCount     = 0;
    doneAtBeat    = 0;
    rst_n         = 1'b0;
    pixelValid    = 1'b0;
    pixelIn       = '0;
    clearOverflow = 1'b0;
    axisIf.tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 32'(axisIf.tvalid), 32'd0);
    checkOutput("rst_level", 32'(fifoLevel), 32'd0);
    checkOutput("rst_overflow", 32'(overflowFlag), 32'd0);
    checkOutput("rst_frame_done", 32'(frameDone), 32'd0);
    checkOutput("rst_beat_fields",
                32'({axisIf.tuser, axisIf.tlast, axisIf.tdata}), 32'd0);
    rst_n = 1'b1;

    // Small frame, continuous input, sink always ready
    axisIf.tready = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("idle_tvalid", 32'(axisIf.tvalid), 32'd0);
    beatBase = gotBeats.size();
    doneBase = doneCount;
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("first_tvalid", 32'(axisIf.tvalid), 32'd1);
    checkOutput("first_level", 32'(fifoLevel), 32'd1);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b0);
    end
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      expectBeat(DW'(i), (i == 0), (i == 3) || (i == 7));
    end
    compareBeats("frame", beatBase);
    checkOutput("frame_done_count", 32'(doneCount - doneBase), 32'd1);
    checkOutput("frame_done_timing", 32'(doneAtBeat - beatBase), 32'd8);
    checkOutput("frame_level_empty", 32'(fifoLevel), 32'd0);

    // Backpressure: fill all 16 slots with the sink stalled
    axisIf.tready = 1'b0;
    beatBase = gotBeats.size();
    doneBase = doneCount;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'h10 + DW'(i), 1'b0);
      if (i == 0) begin
        checkOutput("bp_head_early", 32'(axisIf.tdata), 32'h10);
      end
    end
    checkOutput("bp_level_full", 32'(fifoLevel), 32'd16);
    checkOutput("bp_no_overflow", 32'(overflowFlag), 32'd0);
    checkOutput("bp_tvalid_held", 32'(axisIf.tvalid), 32'd1);
    checkOutput("bp_head_held",
                32'({axisIf.tuser, axisIf.tlast, axisIf.tdata}), 32'h210);

    // Seventeenth pixel is dropped
    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("ovf_set", 32'(overflowFlag), 32'd1);
    checkOutput("ovf_level", 32'(fifoLevel), 32'd16);
    checkOutput("ovf_head_held", 32'(axisIf.tdata), 32'h10);

    // Drop and clear together: the drop wins
    applyStimulus(1'b1, 8'hBB, 1'b1);
    checkOutput("ovf_clear_and_drop", 32'(overflowFlag), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovf_cleared", 32'(overflowFlag), 32'd0);

    // Full FIFO with a simultaneous pop accepts the pixel
    axisIf.tready = 1'b1;
    applyStimulus(1'b1, 8'hCC, 1'b0);
    checkOutput("full_pop_level", 32'(fifoLevel), 32'd16);
    checkOutput("full_pop_no_overflow", 32'(overflowFlag), 32'd0);
    applyStimulus(1'b1, 8'hDD, 1'b0);
    applyStimulus(1'b1, 8'hE0, 1'b0);
    applyStimulus(1'b1, 8'hE1, 1'b0);
    applyStimulus(1'b1, 8'hE2, 1'b0);
    applyStimulus(1'b1, 8'hE3, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    repeat (24) applyStimulus(1'b0, 8'h00, 1'b0);

    // 0xAA (position 16) and 0xBB (17) were dropped but still consumed positions
    for (int i = 0; i < 16; i++) begin
      expectBeat(8'h10 + DW'(i), (i % 8) == 0, (i % 4) == 3);
    end
    expectBeat(8'hCC, 1'b0, 1'b0);
    expectBeat(8'hDD, 1'b0, 1'b1);
    expectBeat(8'hE0, 1'b0, 1'b0);
    expectBeat(8'hE1, 1'b0, 1'b0);
    expectBeat(8'hE2, 1'b0, 1'b0);
    expectBeat(8'hE3, 1'b0, 1'b1);
    expectBeat(8'hF0, 1'b1, 1'b0);
    compareBeats("drain", beatBase);
    checkOutput("drain_frame_done_count", 32'(doneCount - doneBase), 32'd3);
    checkOutput("drain_level", 32'(fifoLevel), 32'd0);
    checkOutput("drain_tvalid", 32'(axisIf.tvalid), 32'd0);

    // Reset in the middle of a frame
    axisIf.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h30 + DW'(i), 1'b0);
    end
    checkOutput("mid_level", 32'(fifoLevel), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tvalid", 32'(axisIf.tvalid), 32'd0);
    checkOutput("mid_rst_level", 32'(fifoLevel), 32'd0);
    checkOutput("mid_rst_fields",
                32'({axisIf.tuser, axisIf.tlast, axisIf.tdata}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    axisIf.tready = 1'b1;
    applyStimulus(1'b1, 8'h55, 1'b0);
    checkOutput("post_rst_tvalid", 32'(axisIf.tvalid), 32'd1);
    checkOutput("post_rst_head",
                32'({axisIf.tuser, axisIf.tlast, axisIf.tdata}), 32'h255);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("post_rst_drained", 32'(fifoLevel), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
